// File: rtl/protosoc_uart_pkg.sv
// ProtoSOC UART shared definitions: receive FSM state encoding and frame constants.
// Pure constants; no timing, no flow control.
package protosoc_uart_pkg;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PARITY    = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// First-word fall-through byte FIFO; write visible at dout one cycle after push.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module uart_rx_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr.
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a FWFT byte FIFO; byte visible 2 clk after stop mid-sample.
// No backpressure on the line: a byte arriving to a full FIFO is dropped and flagged as overrun.
module uart_rx_fifo
   import protosoc_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            rx,
   input  logic                            rdEnable,
   input  logic                            clrErrors,
   output logic [UART_DATA_BITS-1:0]       dataOut,
   output logic                            dataValid,
   output logic [$clog2(FIFO_DEPTH):0]     fifoCount,
   output logic                            frameError,
   output logic                            overrun,
`ifdef UART_RX_PARITY_EN
   output logic                            parityError,
`endif
   output logic                            busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

   logic                      rx_meta;
   logic                      rx_s;
   logic [2:0]                state;
   logic [CW-1:0]             bit_cnt;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      push_req;
   logic                      frame_set;
   logic                      par_bad;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      ovr_set;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_set;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par_bad <= 1'b0;
         par_set <= 1'b0;
      end else begin
         par_set <= 1'b0;
         if (state == ST_PARITY && bit_cnt == BIT_LAST) begin
            par_bad <= rx_s ^ (^shreg);
            par_set <= rx_s ^ (^shreg);
         end
      end
   end
`else
   assign par_bad = 1'b0;
`endif

   // The timer is cleared on every transition so each state measures from its own entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         push_req  <= 1'b0;
         frame_set <= 1'b0;
      end else begin
         push_req  <= 1'b0;
         frame_set <= 1'b0;
         bit_cnt   <= bit_cnt + CW'(1);
         case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               if (!rx_s) state <= ST_START;
            end
            ST_START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                  if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (rx_s) begin
                     push_req <= ~par_bad;
                     state    <= ST_IDLE;
                  end else begin
                     frame_set <= 1'b1;
                     state     <= ST_WAIT_HIGH;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               bit_cnt <= '0;
               if (rx_s) state <= ST_IDLE;
            end
            default: begin
               bit_cnt <= '0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   uart_rx_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (rdEnable),
      .din   (shreg),
      .dout  (dataOut),
      .count (fifoCount),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ovr_set   = push_req & fifo_full & ~(rdEnable & ~fifo_empty);
   assign dataValid = ~fifo_empty;
   assign busy      = (state != ST_IDLE);

   // A new error event takes priority over a coincident clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frameError <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (frame_set)      frameError <= 1'b1;
         else if (clrErrors) frameError <= 1'b0;
         if (ovr_set)        overrun    <= 1'b1;
         else if (clrErrors) overrun    <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         parityError <= 1'b0;
      else if (par_set)   parityError <= 1'b1;
      else if (clrErrors) parityError <= 1'b0;
   end
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver peripheral for ProtoSOC, directly downstream of the `uartRx` pin.
- Samples the asynchronous serial line and deframes 8N1 bytes, plus 8E1 when parity is compiled in.
- Buffers received bytes in a small FIFO that the SoC bus read logic drains.
- Reports sticky framing and overrun errors for the CPU status register.

Parameters:
- CLKS_PER_BIT, 434, system clocks per bit (50 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 8, byte entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state is cleared while low.
- rx  in  1  raw serial line (idle high), asynchronous to clk.
- rdEnable  in  1  pop request from the bus; honoured only when dataValid=1.
- clrErrors  in  1  single-cycle pulse that clears the sticky error flags.
- dataOut  out  8  FIFO head byte (first-word fall-through); 0 when empty.
- dataValid  out  1  FIFO non-empty.
- fifoCount  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- frameError  out  1  sticky; set when the stop bit is sampled low.
- overrun  out  1  sticky; set when a byte is dropped because the FIFO is full.
- busy  out  1  receive FSM is not in IDLE.

Behaviour:
- Reset values:
  - dataOut=0, dataValid=0, fifoCount=0.
  - frameError=0, overrun=0, busy=0.
  - Synchroniser flops=1; FSM=IDLE; pointers=0.
- Synchroniser: 2-flop on rx, producing rxS. All decisions use rxS, which lags the pin by 2 cycles.
- Bit timer: counter 0..CLKS_PER_BIT-1. It is reloaded on every state entry.
- FSM:
  - IDLE: when rxS=0, go to START with the timer at 0.
  - START: at count CLKS_PER_BIT/2-1 (integer divide), resample rxS.
    - rxS=0: go to DATA, bitIdx=0, timer restarts.
    - rxS=1: glitch; return to IDLE with no flags.
  - DATA: every CLKS_PER_BIT cycles (mid-bit), shift rxS into the shift register LSB-first.
    - After bitIdx=7, go to PARITY if compiled in, else to STOP.
  - STOP: sample at mid-bit.
    - rxS=1: byte is good; issue a push request; go to IDLE.
    - rxS=0: set frameError, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxS=1, then go to IDLE. This prevents a break condition from re-triggering START.
- FIFO push: the push occurs in the cycle after the stop-bit sample. dataValid/dataOut reflect the byte on the following cycle, so latency is 2 clk after the stop-bit mid-sample.
- Pop: rdEnable=1 with dataValid=1 advances the read pointer. dataOut shows the next entry on the next cycle. rdEnable while empty is ignored, with no underflow.
- Full:
  - A push while full with no pop drops the byte, sets overrun and leaves FIFO contents unchanged.
  - A simultaneous push and pop while full is accepted; fifoCount is unchanged and overrun is not set.
- Empty: a simultaneous push and pop while empty performs the push only.
- Pointers wrap modulo FIFO_DEPTH. fifoCount saturates at FIFO_DEPTH by construction.
- Sticky flags clear only on clrErrors or reset. If clrErrors coincides with a new error event, the set wins.
- Reset mid-frame: the FSM aborts immediately, the FIFO empties, and the partial byte is lost.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP that samples one bit at mid-bit. The expected bit gives even parity (XOR of data bits).
  - Adds an output port parityError (1 bit, sticky, cleared like the other flags).
  - A bad-parity byte is discarded but the FSM still proceeds to STOP.
- Not defined: no PARITY state, no parityError port; the frame is 10 bits (8N1).

Decomposition:
- Shared package, protosoc_uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - Constants: UART_DATA_BITS=8, default CLKS_PER_BIT.
- Sub-module uart_rx_sync_fifo:
  - Parameterised depth/width, first-word fall-through.
  - Ports: push, pop, din, dout, count, full, empty.
  - Instantiated once. The top module holds the synchroniser, bit timer and FSM.

Test Plan (CLKS_PER_BIT=8, FIFO_DEPTH=4):
- Reset, rx held at 1 for 200 cycles -> dataValid=0, busy=0, all flags 0.
- Send 8N1 byte 0xA5 -> dataValid=1, dataOut=0xA5, fifoCount=1 within 2 clk of the stop mid-sample; pulse rdEnable -> dataValid=0.
- rx low pulse of 3 cycles -> busy rises then falls, fifoCount=0, frameError=0.
- Send 0x3C with stop bit 0, rx held low 40 cycles, then high -> frameError=1, fifoCount=0; next byte 0x81 received normally; clrErrors -> frameError=0.
- Send 5 bytes 0x01..0x05 with no reads -> fifoCount=4, overrun=1; reads return 0x01,0x02,0x03,0x04.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) -> parityError=1, not queued; send 0x07 with parity bit 1 -> dataOut=0x07.
